mc_proc_ldst: RTL and testbench

Parametrised multi-cycle processor core: next generation of the decode/execute/writeback multi-cycle core, with configurable datapath width and register count, an internal register file, decoder and ALU, load/store via a split request/response data-memory port, branches, and a halt/run handshake. One instruction is in flight at a time and sequencing is a single state machine. It sits between the instruction memory and data memory exactly as the earlier core did and exposes a retired-instruction counter.

---
 rtl/mc_proc_ldst_if.sv | 39 +++
 rtl/mc_proc_ldst.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc_proc_ldst.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_proc_ldst_if.sv
// Bus bundle for mc_proc_ldst: run/halt handshake, instruction fetch port,
// split request/response data-memory port and the pc/retired status outputs.
// The "master" modport is the core side, "slave" is the environment side.
interface mc_proc_ldst_if #(
  parameter int XLEN = 32
);
  logic            run__ENA;
  logic [XLEN-1:0] run_pc;
  logic            run__RDY;
  logic [XLEN-1:0] pgm_read_pc;
  logic [31:0]     pgm_read;
  logic            pgm_read__RDY;
  logic            dmem_request__ENA;
  logic            dmem_request_write_en;
  logic [XLEN-1:0] dmem_request_addr;
  logic [XLEN-1:0] dmem_request_data;
  logic            dmem_request__RDY;
  logic [XLEN-1:0] dmem_response;
  logic            dmem_response__RDY;
  logic            dmem_response__ENA;
  logic [XLEN-1:0] pc;
  logic [31:0]     retired;

  modport master (
    input  run__ENA, run_pc, pgm_read, pgm_read__RDY,
           dmem_request__RDY, dmem_response, dmem_response__RDY,
    output run__RDY, pgm_read_pc, dmem_request__ENA, dmem_request_write_en,
           dmem_request_addr, dmem_request_data, dmem_response__ENA,
           pc, retired
  );

  modport slave (
    output run__ENA, run_pc, pgm_read, pgm_read__RDY,
           dmem_request__RDY, dmem_response, dmem_response__RDY,
    input  run__RDY, pgm_read_pc, dmem_request__ENA, dmem_request_write_en,
           dmem_request_addr, dmem_request_data, dmem_response__ENA,
           pc, retired
  );
endinterface

// File: rtl/mc_proc_ldst.sv
// mc_proc_ldst: multi-cycle decode/execute/writeback core, one instruction in
// flight, sequenced by a single state machine (IDLE/FETCH/EXEC/MREQ/MRSP/WB).
// Optional feature: define MC_PROC_MUL_EN to make ALU funct 8 an unsigned
// multiply (low XLEN bits); otherwise funct 8 yields 0 like other unused funct.
module mc_proc_ldst #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 16,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic           CLK,
  input  logic           RST,
  mc_proc_ldst_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MREQ  = 3'd3,
    S_MRSP  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  localparam int              SHW     = $clog2(XLEN);
  localparam logic [3:0]      OP_ALU  = 4'd0;
  localparam logic [3:0]      OP_ADDI = 4'd1;
  localparam logic [3:0]      OP_LD   = 4'd2;
  localparam logic [3:0]      OP_ST   = 4'd3;
  localparam logic [3:0]      OP_BEQ  = 4'd4;
  localparam logic [3:0]      OP_JR   = 4'd5;
  localparam logic [3:0]      OP_HALT = 4'd15;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_retired;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_we;
  // Sized for the full 4-bit index space; entries at or above NREGS are never
  // written and never read, so they reduce to constants.
  logic [XLEN-1:0] r_regs [0:15];

  // Decoded instruction fields and operand values
  logic [3:0]      w_op, w_rd, w_rs1, w_rs2, w_funct;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_ea, w_alu;
  logic [SHW-1:0]  w_shamt;
  logic            w_slt;
  logic            w_rd_ok;

  // Control strobes from the sequencer
  logic            w_ld_ir, w_ex_res, w_ex_mem, w_rsp_take;
  logic            w_pc_ld, w_retire, w_rf_we;
  logic [XLEN-1:0] w_pc_nxt;

  assign w_op      = r_ir[31:28];
  assign w_rd      = r_ir[27:24];
  assign w_rs1     = r_ir[23:20];
  assign w_rs2     = r_ir[19:16];
  assign w_funct   = r_ir[3:0];
  assign w_imm     = XLEN'($signed(r_ir[15:0]));
  // r0 and indices beyond the implemented register count read as zero
  assign w_rs1_val = (w_rs1 != 4'd0 && int'(w_rs1) < NREGS) ? r_regs[w_rs1] : {XLEN{1'b0}};
  assign w_rs2_val = (w_rs2 != 4'd0 && int'(w_rs2) < NREGS) ? r_regs[w_rs2] : {XLEN{1'b0}};
  assign w_rd_ok   = (w_rd != 4'd0) && (int'(w_rd) < NREGS);
  assign w_ea      = w_rs1_val + w_imm;
  assign w_shamt   = w_rs2_val[SHW-1:0];
  assign w_slt     = $signed(w_rs1_val) < $signed(w_rs2_val);

  // ALU result for op 0, selected by funct
  always_comb begin
    w_alu = {XLEN{1'b0}};
    case (w_funct)
      4'd0:    w_alu = w_rs1_val + w_rs2_val;
      4'd1:    w_alu = w_rs1_val - w_rs2_val;
      4'd2:    w_alu = w_rs1_val & w_rs2_val;
      4'd3:    w_alu = w_rs1_val | w_rs2_val;
      4'd4:    w_alu = w_rs1_val ^ w_rs2_val;
      4'd5:    w_alu = w_rs1_val << w_shamt;
      4'd6:    w_alu = w_rs1_val >> w_shamt;
      4'd7:    w_alu = {{(XLEN-1){1'b0}}, w_slt};
`ifdef MC_PROC_MUL_EN
      4'd8:    w_alu = w_rs1_val * w_rs2_val;
`endif
      default: w_alu = {XLEN{1'b0}};
    endcase
  end

  // Sequencer: next state and per-state control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ld_ir     = 1'b0;
    w_ex_res    = 1'b0;
    w_ex_mem    = 1'b0;
    w_rsp_take  = 1'b0;
    w_pc_ld     = 1'b0;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    w_rf_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run__ENA) begin
          w_pc_ld     = 1'b1;
          w_pc_nxt    = bus.run_pc;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.pgm_read__RDY) begin
          w_ld_ir     = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        case (w_op)
          OP_ALU, OP_ADDI: begin
            w_ex_res    = 1'b1;
            w_state_nxt = S_WB;
          end
          OP_LD, OP_ST: begin
            w_ex_mem    = 1'b1;
            w_state_nxt = S_MREQ;
          end
          OP_BEQ: begin
            w_pc_ld     = 1'b1;
            w_pc_nxt    = (w_rs1_val == w_rs2_val) ? (r_pc + {w_imm[XLEN-3:0], 2'b00})
                                                   : (r_pc + PC_STEP);
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
          OP_JR: begin
            w_pc_ld     = 1'b1;
            w_pc_nxt    = w_ea;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
          OP_HALT: begin
            w_retire    = 1'b1;
            w_state_nxt = S_IDLE;
          end
          default: begin
            // unassigned opcodes behave as NOP: nothing latched, no write
            w_state_nxt = S_WB;
          end
        endcase
      end
      S_MREQ: begin
        if (bus.dmem_request__RDY) begin
          w_state_nxt = r_we ? S_WB : S_MRSP;
        end else begin
          w_state_nxt = S_MREQ;
        end
      end
      S_MRSP: begin
        if (bus.dmem_response__RDY) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_MRSP;
        end
      end
      S_WB: begin
        w_rf_we     = ((w_op == OP_ALU) || (w_op == OP_ADDI) || (w_op == OP_LD)) && w_rd_ok;
        w_pc_ld     = 1'b1;
        w_pc_nxt    = r_pc + PC_STEP;
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter, retired counter and instruction register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
      r_ir      <= 32'd0;
    end else begin
      if (w_pc_ld)  r_pc      <= w_pc_nxt;
      if (w_retire) r_retired <= r_retired + 32'd1;
      if (w_ld_ir)  r_ir      <= bus.pgm_read;
    end
  end

  // Execute-stage latches: writeback value and memory request fields
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= {XLEN{1'b0}};
      r_addr   <= {XLEN{1'b0}};
      r_wdata  <= {XLEN{1'b0}};
      r_we     <= 1'b0;
    end else begin
      if (w_ex_res) begin
        r_result <= (w_op == OP_ADDI) ? w_ea : w_alu;
      end else if (w_rsp_take) begin
        r_result <= bus.dmem_response;
      end
      if (w_ex_mem) begin
        r_addr  <= w_ea;
        r_wdata <= w_rs2_val;
        r_we    <= (w_op == OP_ST);
      end
    end
  end

  // Register file write port, used only in WB
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (w_rf_we) begin
        r_regs[w_rd] <= r_result;
      end
    end
  end

  // Outputs are decoded from the state register, so a reset drops the
  // request immediately; request fields read zero outside MREQ.
  assign bus.run__RDY              = (r_state == S_IDLE);
  assign bus.pgm_read_pc           = r_pc;
  assign bus.pc                    = r_pc;
  assign bus.retired               = r_retired;
  assign bus.dmem_request__ENA     = (r_state == S_MREQ);
  assign bus.dmem_request_write_en = (r_state == S_MREQ) ? r_we : 1'b0;
  assign bus.dmem_request_addr     = (r_state == S_MREQ) ? r_addr : {XLEN{1'b0}};
  assign bus.dmem_request_data     = (r_state == S_MREQ) ? r_wdata : {XLEN{1'b0}};
  assign bus.dmem_response__ENA    = (r_state == S_MRSP) && bus.dmem_response__RDY;

endmodule

// File: tb/tb_mc_proc_ldst.sv
// Directed testbench for mc_proc_ldst (XLEN=32, NREGS=8, RESET_PC=0x80).
// Instruction memory is a word array; data memory is a small model with
// programmable request-accept and response delays.
module tb_mc_proc_ldst;
  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mc_proc_ldst_if #(.XLEN(32)) bus ();

  mc_proc_ldst #(.XLEN(32), .NREGS(8), .RESET_PC(RST_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Instruction memory (always ready)
  logic [31:0] imem [0:255];
  assign bus.pgm_read      = imem[bus.pgm_read_pc[9:2]];
  assign bus.pgm_read__RDY = 1'b1;

  // Data memory model
  logic [31:0] dmem [0:63];
  int          req_delay = 0;
  int          rsp_delay = 0;
  logic        stray_rsp = 1'b0;
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'd0;
  logic [31:0] pre_data = 32'd0;
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] ld_addr = 32'd0;

  assign bus.dmem_request__RDY  = bus.dmem_request__ENA && (req_cnt >= req_delay);
  assign bus.dmem_response__RDY = (pending && (rsp_cnt >= rsp_delay)) || stray_rsp;
  assign bus.dmem_response      = dmem[ld_addr[7:2]];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_cnt <= 0;
      rsp_cnt <= 0;
      pending <= 1'b0;
    end else begin
      if (pre_en) dmem[pre_addr[7:2]] <= pre_data;
      if (bus.dmem_request__ENA && !bus.dmem_request__RDY) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
      if (bus.dmem_request__ENA && bus.dmem_request__RDY) begin
        if (bus.dmem_request_write_en) begin
          dmem[bus.dmem_request_addr[7:2]] <= bus.dmem_request_data;
        end else begin
          pending <= 1'b1;
          ld_addr <= bus.dmem_request_addr;
          rsp_cnt <= 0;
        end
      end else if (pending) begin
        if (bus.dmem_response__ENA) pending <= 1'b0;
        else rsp_cnt <= rsp_cnt + 1;
      end
    end
  end

  // Request/response monitor, sampled on the falling edge
  int          ena_cycles = 0;
  int          rsp_pulses = 0;
  int          unstable = 0;
  logic        have_first = 1'b0;
  logic [31:0] f_addr = 32'd0;
  logic [31:0] f_data = 32'd0;
  logic        f_we = 1'b0;

  always @(negedge CLK) begin
    if (bus.dmem_request__ENA) begin
      ena_cycles <= ena_cycles + 1;
      if (!have_first) begin
        f_addr <= bus.dmem_request_addr;
        f_data <= bus.dmem_request_data;
        f_we   <= bus.dmem_request_write_en;
      end else if (bus.dmem_request_addr !== f_addr || bus.dmem_request_data !== f_data ||
                   bus.dmem_request_write_en !== f_we) begin
        unstable <= unstable + 1;
      end
      have_first <= !bus.dmem_request__RDY;
    end
    if (bus.dmem_response__ENA) rsp_pulses <= rsp_pulses + 1;
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge CLK);
    pre_en = 1'b0;
  endtask

  // Start the core at 'start' and count cycles until it is idle again (-1 on timeout)
  task automatic run_prog(input logic [31:0] start, input int budget, output int cycles);
    @(negedge CLK);
    bus.run_pc = start; bus.run__ENA = 1'b1;
    @(posedge CLK); #1;
    bus.run__ENA = 1'b0;
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge CLK); #1;
      if (bus.run__RDY) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_cmp++; if (bus.run__RDY !== 1'b1) begin n_err++; $display("FAIL rst_rdy got=%b exp=1", bus.run__RDY); end
    n_cmp++; if (bus.dmem_request__ENA !== 1'b0) begin n_err++; $display("FAIL rst_req_ena got=%b exp=0", bus.dmem_request__ENA); end
    n_cmp++; if ({bus.dmem_request_write_en, bus.dmem_request_addr, bus.dmem_request_data} !== 65'd0) begin n_err++; $display("FAIL rst_req_fields got=%b/%h/%h exp=0", bus.dmem_request_write_en, bus.dmem_request_addr, bus.dmem_request_data); end
    n_cmp++; if (bus.dmem_response__ENA !== 1'b0) begin n_err++; $display("FAIL rst_rsp_ena got=%b exp=0", bus.dmem_response__ENA); end
    n_cmp++; if (bus.pc !== RST_PC || bus.pgm_read_pc !== RST_PC) begin n_err++; $display("FAIL rst_pc got=%h/%h exp=%h", bus.pc, bus.pgm_read_pc, RST_PC); end
    n_cmp++; if (bus.retired !== 32'd0) begin n_err++; $display("FAIL rst_retired got=%0d exp=0", bus.retired); end
    RST = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if (bus.run__RDY !== 1'b1 || bus.pc !== RST_PC) begin n_err++; $display("FAIL rst_idle got=%b/%h exp=1/%h", bus.run__RDY, bus.pc, RST_PC); end
  endtask

  task automatic test_basic();
    int cyc;
    clear_imem();
    imem[64] = enc(4'd1, 4'd1, 4'd0, 4'd0, 16'd5);
    imem[65] = enc(4'd1, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    imem[66] = enc(4'd0, 4'd3, 4'd1, 4'd2, 16'd0);
    imem[67] = HALT_W;
    run_prog(32'h0000_0100, 50, cyc);
    n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL basic_cycles got=%0d exp=11", cyc); end
    n_cmp++; if (dut.r_regs[3] !== 32'd2) begin n_err++; $display("FAIL basic_r3 got=%h exp=2", dut.r_regs[3]); end
    n_cmp++; if (dut.r_regs[2] !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL basic_r2 got=%h exp=fffffffd", dut.r_regs[2]); end
    n_cmp++; if (bus.retired !== 32'd4) begin n_err++; $display("FAIL basic_retired got=%0d exp=4", bus.retired); end
    n_cmp++; if (bus.pc !== 32'h0000_010C) begin n_err++; $display("FAIL basic_pc got=%h exp=10c", bus.pc); end
  endtask

  task automatic test_ldst();
    int cyc, e0, p0, u0;
    poke(32'h80, 32'hDEAD_BEEF);
    poke(32'h40, 32'h0000_0000);
    clear_imem();
    imem[0] = enc(4'd2, 4'd1, 4'd0, 4'd0, 16'h0080);
    imem[4] = enc(4'd3, 4'd0, 4'd0, 4'd1, 16'h0040);
    imem[8] = enc(4'd2, 4'd4, 4'd0, 4'd0, 16'h0040);
    run_prog(32'h0, 50, cyc);
    n_cmp++; if (cyc !== 7 || dut.r_regs[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_zero_wait got=%0d/%h exp=7/deadbeef", cyc, dut.r_regs[1]); end
    req_delay = 3;
    e0 = ena_cycles; u0 = unstable;
    run_prog(32'h10, 50, cyc);
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL st_cycles got=%0d exp=9", cyc); end
    n_cmp++; if (ena_cycles - e0 !== 4) begin n_err++; $display("FAIL st_ena_hold got=%0d exp=4", ena_cycles - e0); end
    n_cmp++; if (f_addr !== 32'h40 || f_we !== 1'b1 || f_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_fields got=%h/%b/%h exp=40/1/deadbeef", f_addr, f_we, f_data); end
    n_cmp++; if (unstable - u0 !== 0) begin n_err++; $display("FAIL st_stable got=%0d exp=0", unstable - u0); end
    n_cmp++; if (dmem[16] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_mem got=%h exp=deadbeef", dmem[16]); end
    req_delay = 0; rsp_delay = 2;
    p0 = rsp_pulses;
    run_prog(32'h20, 50, cyc);
    rsp_delay = 0;
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL ld_cycles got=%0d exp=9", cyc); end
    n_cmp++; if (dut.r_regs[4] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_r4 got=%h exp=deadbeef", dut.r_regs[4]); end
    n_cmp++; if (rsp_pulses - p0 !== 1) begin n_err++; $display("FAIL ld_rsp_pulses got=%0d exp=1", rsp_pulses - p0); end
    n_cmp++; if (bus.retired !== 32'd10) begin n_err++; $display("FAIL ldst_retired got=%0d exp=10", bus.retired); end
  endtask

  task automatic test_branch();
    int cyc;
    clear_imem();
    imem[8] = enc(4'd4, 4'd0, 4'd1, 4'd1, 16'hFFFE);
    run_prog(32'h20, 50, cyc);
    n_cmp++; if (cyc !== 4 || bus.pc !== 32'h18) begin n_err++; $display("FAIL beq_taken got=%0d/%h exp=4/18", cyc, bus.pc); end
    imem[8] = enc(4'd4, 4'd0, 4'd1, 4'd0, 16'hFFFE);
    run_prog(32'h20, 50, cyc);
    n_cmp++; if (cyc !== 4 || bus.pc !== 32'h24) begin n_err++; $display("FAIL beq_not_taken got=%0d/%h exp=4/24", cyc, bus.pc); end
    imem[12] = enc(4'd1, 4'd5, 4'd0, 4'd0, 16'hFFFC);
    imem[13] = enc(4'd5, 4'd0, 4'd5, 4'd0, 16'd8);
    run_prog(32'h30, 50, cyc);
    n_cmp++; if (cyc !== 7 || bus.pc !== 32'h4) begin n_err++; $display("FAIL jr_wrap got=%0d/%h exp=7/4", cyc, bus.pc); end
    n_cmp++; if (bus.retired !== 32'd17) begin n_err++; $display("FAIL branch_retired got=%0d exp=17", bus.retired); end
  endtask

  task automatic test_alu();
    int cyc;
    logic [31:0] exp_mul;
`ifdef MC_PROC_MUL_EN
    exp_mul = 32'd42;
`else
    exp_mul = 32'd0;
`endif
    poke(32'h44, 32'hFFFF_FFFF);
    poke(32'h48, 32'hFFFF_FFFF);
    clear_imem();
    imem[16] = enc(4'd1, 4'd0, 4'd0, 4'd0, 16'd7);
    imem[17] = enc(4'd1, 4'd12, 4'd0, 4'd0, 16'd9);
    imem[18] = enc(4'd3, 4'd0, 4'd0, 4'd0, 16'h0044);
    imem[19] = enc(4'd3, 4'd0, 4'd0, 4'd12, 16'h0048);
    imem[20] = enc(4'd1, 4'd1, 4'd0, 4'd0, 16'hFFFF);
    imem[21] = enc(4'd1, 4'd2, 4'd0, 4'd0, 16'd1);
    imem[22] = enc(4'd0, 4'd3, 4'd1, 4'd2, 16'd7);
    imem[23] = enc(4'd0, 4'd4, 4'd2, 4'd1, 16'd7);
    imem[24] = enc(4'd1, 4'd5, 4'd0, 4'd0, 16'd33);
    imem[25] = enc(4'd1, 4'd6, 4'd0, 4'd0, 16'd3);
    imem[26] = enc(4'd0, 4'd7, 4'd6, 4'd5, 16'd5);
    run_prog(32'h40, 100, cyc);
    n_cmp++; if (cyc !== 37) begin n_err++; $display("FAIL alu1_cycles got=%0d exp=37", cyc); end
    n_cmp++; if (dmem[17] !== 32'd0 || dmem[18] !== 32'd0) begin n_err++; $display("FAIL r0_r12_read got=%h/%h exp=0/0", dmem[17], dmem[18]); end
    n_cmp++; if (dut.r_regs[3] !== 32'd1 || dut.r_regs[4] !== 32'd0) begin n_err++; $display("FAIL slt got=%h/%h exp=1/0", dut.r_regs[3], dut.r_regs[4]); end
    n_cmp++; if (dut.r_regs[7] !== 32'd6) begin n_err++; $display("FAIL sll33 got=%h exp=6", dut.r_regs[7]); end
    imem[36] = enc(4'd1, 4'd1, 4'd0, 4'd0, 16'd7);
    imem[37] = enc(4'd1, 4'd2, 4'd0, 4'd0, 16'd6);
    imem[38] = enc(4'd0, 4'd3, 4'd1, 4'd2, 16'd8);
    imem[39] = enc(4'd0, 4'd4, 4'd1, 4'd2, 16'd1);
    imem[40] = enc(4'd0, 4'd5, 4'd1, 4'd2, 16'd3);
    imem[41] = enc(4'd0, 4'd6, 4'd1, 4'd2, 16'd2);
    imem[42] = enc(4'd0, 4'd7, 4'd1, 4'd2, 16'd9);
    run_prog(32'h90, 100, cyc);
    n_cmp++; if (cyc !== 23) begin n_err++; $display("FAIL alu2_cycles got=%0d exp=23", cyc); end
    n_cmp++; if (dut.r_regs[3] !== exp_mul) begin n_err++; $display("FAIL funct8 got=%h exp=%h", dut.r_regs[3], exp_mul); end
    n_cmp++; if (dut.r_regs[4] !== 32'd1 || dut.r_regs[5] !== 32'd7 || dut.r_regs[6] !== 32'd6) begin n_err++; $display("FAIL sub_or_and got=%h/%h/%h exp=1/7/6", dut.r_regs[4], dut.r_regs[5], dut.r_regs[6]); end
    n_cmp++; if (dut.r_regs[7] !== 32'd0) begin n_err++; $display("FAIL funct9 got=%h exp=0", dut.r_regs[7]); end
    n_cmp++; if (bus.retired !== 32'd37) begin n_err++; $display("FAIL alu_retired got=%0d exp=37", bus.retired); end
  endtask

  task automatic test_back_to_back();
    int cyc, p0;
    clear_imem();
    imem[40] = enc(4'd1, 4'd1, 4'd0, 4'd0, 16'h0123);
    imem[41] = enc(4'd3, 4'd0, 4'd0, 4'd1, 16'h0050);
    imem[42] = enc(4'd2, 4'd2, 4'd0, 4'd0, 16'h0050);
    p0 = rsp_pulses;
    stray_rsp = 1'b1;
    run_prog(32'hA0, 50, cyc);
    stray_rsp = 1'b0;
    n_cmp++; if (cyc !== 14) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=14", cyc); end
    n_cmp++; if (dut.r_regs[2] !== 32'h123) begin n_err++; $display("FAIL b2b_r2 got=%h exp=123", dut.r_regs[2]); end
    n_cmp++; if (rsp_pulses - p0 !== 1) begin n_err++; $display("FAIL stray_rsp_pulses got=%0d exp=1", rsp_pulses - p0); end
    n_cmp++; if (bus.retired !== 32'd41) begin n_err++; $display("FAIL b2b_retired got=%0d exp=41", bus.retired); end
  endtask

  task automatic test_reset_midreq();
    logic seen;
    clear_imem();
    imem[24] = enc(4'd3, 4'd0, 4'd0, 4'd1, 16'h0058);
    req_delay = 1000;
    @(negedge CLK);
    bus.run_pc = 32'h60; bus.run__ENA = 1'b1;
    @(posedge CLK); #1;
    bus.run__ENA = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.dmem_request__ENA) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midreq_reach got=%b exp=1", seen); end
    bus.run_pc = 32'h200; bus.run__ENA = 1'b1;
    @(posedge CLK); #1;
    bus.run__ENA = 1'b0;
    n_cmp++; if (bus.pc !== 32'h60 || bus.run__RDY !== 1'b0 || bus.dmem_request__ENA !== 1'b1) begin n_err++; $display("FAIL busy_run_ignored got=%h/%b/%b exp=60/0/1", bus.pc, bus.run__RDY, bus.dmem_request__ENA); end
    @(negedge CLK); #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (bus.dmem_request__ENA !== 1'b0 || bus.dmem_request_addr !== 32'd0) begin n_err++; $display("FAIL midreq_ena_drop got=%b/%h exp=0/0", bus.dmem_request__ENA, bus.dmem_request_addr); end
    n_cmp++; if (bus.pc !== RST_PC || bus.retired !== 32'd0 || bus.run__RDY !== 1'b1) begin n_err++; $display("FAIL midreq_state got=%h/%0d/%b exp=%h/0/1", bus.pc, bus.retired, bus.run__RDY, RST_PC); end
    n_cmp++; if (dut.r_regs[1] !== 32'd0) begin n_err++; $display("FAIL midreq_regs got=%h exp=0", dut.r_regs[1]); end
    @(negedge CLK);
    RST = 1'b0;
    req_delay = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (bus.run__RDY !== 1'b1 || bus.pc !== RST_PC) begin n_err++; $display("FAIL post_rst_idle got=%b/%h exp=1/%h", bus.run__RDY, bus.pc, RST_PC); end
  endtask

  initial begin
    bus.run__ENA = 1'b0;
    bus.run_pc   = 32'd0;
    clear_imem();
    test_reset();
    test_basic();
    test_ldst();
    test_branch();
    test_alu();
    test_back_to_back();
    test_reset_midreq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
